// File: rtl/sdram_ctrl_pkg.sv
// Shared types and sizing for the SDRAM controller write buffer.
package sdram_ctrl_pkg;

   localparam int unsigned HADDR_SIZE       = 23;
   localparam int unsigned HDATA_SIZE       = 32;
   localparam int unsigned WRITEBUFFER_SIZE = 256;
   localparam int unsigned BE               = HDATA_SIZE / 8;
   localparam int unsigned BUF_WORDS        = WRITEBUFFER_SIZE / HDATA_SIZE;
   localparam int unsigned ALSB             = $clog2(BE);
   localparam int unsigned IDXW             = $clog2(BUF_WORDS);
   localparam int unsigned TAGW             = HADDR_SIZE - IDXW - ALSB;
   localparam int unsigned TMRW             = 4;

   typedef enum logic [1:0] {EMPTY, FILL, REQ, DRAIN} wrbuf_state_t;

   typedef struct packed {
      logic [HDATA_SIZE-1:0] data;
      logic [BE-1:0]         be;
   } wrbuf_entry_t;

endpackage

// File: rtl/sdram_ctrl_wrbuf_mem.sv
// Generic register array for the write buffer: per-byte write port, async read port,
// and the full set of byte-valid flags exposed for block-complete detection.
module sdram_ctrl_wrbuf_mem
   import sdram_ctrl_pkg::*;
(
   input  logic                      HCLK,
   input  logic                      PRESETn,
   input  logic                      we_i,
   input  logic [IDXW-1:0]           waddr_i,
   input  logic [BE-1:0]             wbe_i,
   input  logic [HDATA_SIZE-1:0]     wdata_i,
   input  logic                      clr_i,
   input  logic [IDXW-1:0]           raddr_i,
   output wrbuf_entry_t              rdata_o,
   output logic [BUF_WORDS*BE-1:0]   be_flags_o
);

   logic [HDATA_SIZE-1:0] data_q [BUF_WORDS];
   logic [BE-1:0]         be_q   [BUF_WORDS];

   // Data bytes carry no reset; the valid flags decide what is meaningful.
   always_ff @(posedge HCLK) begin
      for (int unsigned w = 0; w < BUF_WORDS; w++) begin
         for (int unsigned b = 0; b < BE; b++) begin
            if (we_i && (waddr_i == IDXW'(w)) && wbe_i[b])
               data_q[w][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge HCLK or posedge PRESETn) begin
      if (PRESETn) begin
         for (int unsigned w = 0; w < BUF_WORDS; w++) be_q[w] <= '0;
      end else if (clr_i) begin
         for (int unsigned w = 0; w < BUF_WORDS; w++) be_q[w] <= '0;
      end else if (we_i) begin
         be_q[waddr_i] <= be_q[waddr_i] | wbe_i;
      end
   end

   always_comb begin
      rdata_o.data = data_q[raddr_i];
      rdata_o.be   = be_q[raddr_i];
      for (int unsigned w = 0; w < BUF_WORDS; w++)
         be_flags_o[w*BE +: BE] = be_q[w];
   end

endmodule

// File: rtl/sdram_ctrl_writebuffer.sv
// Coalescing write buffer: merges AHB writes into one aligned block and hands it
// to the SDRAM sequencer as a single masked burst write.
module sdram_ctrl_writebuffer
   import sdram_ctrl_pkg::*;
(
   input  logic                  HCLK,
   input  logic                  PRESETn,
   input  logic                  wr_req_i,
   input  logic [HADDR_SIZE-1:0] wr_addr_i,
   input  logic [BE-1:0]         wr_be_i,
   input  logic [HDATA_SIZE-1:0] wr_data_i,
   output logic                  wr_ready_o,
   input  logic                  flush_i,
   input  logic [TMRW-1:0]       csr_timeout_i,
   input  logic [HADDR_SIZE-1:0] rd_chk_addr_i,
   output logic                  rd_hit_o,
   output logic                  buf_req_o,
   input  logic                  buf_ack_i,
   output logic [TAGW-1:0]       buf_tag_o,
   input  logic                  buf_rd_i,
   output logic [HDATA_SIZE-1:0] buf_data_o,
   output logic [BE-1:0]         buf_be_o,
   output logic                  buf_last_o,
   output logic                  empty_o
);

   wrbuf_state_t            state_q, state_d;
   logic [TAGW-1:0]         tag_q, tag_d;
   logic [TMRW-1:0]         timer_q, timer_d;
   logic [IDXW-1:0]         idx_q, idx_d;
   logic                    mem_clr;
   logic                    accept;
   logic                    tag_hit;
   logic [TAGW-1:0]         wr_tag;
   logic [IDXW-1:0]         wr_idx;
   logic [BUF_WORDS*BE-1:0] be_flags, be_merged;
   wrbuf_entry_t            rd_entry;
   logic                    unused_addr_bits;

   assign wr_tag  = wr_addr_i[HADDR_SIZE-1 -: TAGW];
   assign wr_idx  = wr_addr_i[ALSB +: IDXW];
   assign tag_hit = (wr_tag == tag_q);
   assign unused_addr_bits = ^{wr_addr_i[ALSB-1:0], rd_chk_addr_i[HADDR_SIZE-TAGW-1:0]};

   assign wr_ready_o = (state_q == EMPTY) || ((state_q == FILL) && tag_hit && !flush_i);
   assign accept     = wr_req_i && wr_ready_o;

   sdram_ctrl_wrbuf_mem u_mem (
      .HCLK       (HCLK),
      .PRESETn    (PRESETn),
      .we_i       (accept),
      .waddr_i    (wr_idx),
      .wbe_i      (wr_be_i),
      .wdata_i    (wr_data_i),
      .clr_i      (mem_clr),
      .raddr_i    (idx_q),
      .rdata_o    (rd_entry),
      .be_flags_o (be_flags)
   );

   // Flags as they will be after this cycle's write, so a completing write exits FILL at once.
   always_comb begin
      be_merged = be_flags;
      if (accept)
         be_merged[int'(wr_idx)*BE +: BE] = be_flags[int'(wr_idx)*BE +: BE] | wr_be_i;
   end

   always_ff @(posedge HCLK or posedge PRESETn) begin
      if (PRESETn) begin
         state_q <= EMPTY;
         tag_q   <= '0;
         timer_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      mem_clr = 1'b0;
      case (state_q)
         EMPTY: begin
            if (wr_req_i) begin
               tag_d   = wr_tag;
               timer_d = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            timer_d = accept ? '0 : timer_q + TMRW'(1);
            // flush_i outranks a pending write, which outranks the idle timeout
            if (flush_i)
               state_d = REQ;
            else if (accept)
               state_d = (&be_merged) ? REQ : FILL;
            else if (wr_req_i)
               state_d = REQ;
            else if ((csr_timeout_i != '0) && (timer_q == csr_timeout_i))
               state_d = REQ;
         end
         REQ: begin
            if (buf_ack_i) begin
               idx_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (buf_rd_i) begin
               if (idx_q == IDXW'(BUF_WORDS-1)) begin
                  mem_clr = 1'b1;
                  idx_d   = '0;
                  state_d = EMPTY;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign empty_o    = (state_q == EMPTY);
   assign buf_req_o  = (state_q == REQ);
   assign buf_tag_o  = tag_q;
   assign buf_last_o = (state_q == DRAIN) && (idx_q == IDXW'(BUF_WORDS-1));
   assign buf_data_o = (state_q == DRAIN) ? rd_entry.data : '0;
   assign buf_be_o   = (state_q == DRAIN) ? rd_entry.be   : '0;
   assign rd_hit_o   = (state_q != EMPTY) && (rd_chk_addr_i[HADDR_SIZE-1 -: TAGW] == tag_q);

endmodule

// File: tb/tb_sdram_ctrl_writebuffer.sv
// Self-checking bench for sdram_ctrl_writebuffer: directed scenarios plus randomized
// blocks, checked against a per-block byte-merge scoreboard.
module tb_sdram_ctrl_writebuffer;

   logic        HCLK = 1'b0;
   logic        PRESETn;
   logic        wr_req;
   logic [22:0] wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        flush;
   logic [3:0]  csr_timeout;
   logic [22:0] rd_chk_addr;
   logic        rd_hit;
   logic        buf_req;
   logic        buf_ack;
   logic [17:0] buf_tag;
   logic        buf_rd;
   logic [31:0] buf_data;
   logic [3:0]  buf_be;
   logic        buf_last;
   logic        empty;

   int errors = 0;
   int checks = 0;

   // Reference block: tag plus merged bytes and valid lanes per word.
   logic        mdl_valid;
   logic [17:0] mdl_tag;
   logic [31:0] mdl_data [8];
   logic [3:0]  mdl_be   [8];

   sdram_ctrl_writebuffer dut (
      .HCLK          (HCLK),
      .PRESETn       (PRESETn),
      .wr_req_i      (wr_req),
      .wr_addr_i     (wr_addr),
      .wr_be_i       (wr_be),
      .wr_data_i     (wr_data),
      .wr_ready_o    (wr_ready),
      .flush_i       (flush),
      .csr_timeout_i (csr_timeout),
      .rd_chk_addr_i (rd_chk_addr),
      .rd_hit_o      (rd_hit),
      .buf_req_o     (buf_req),
      .buf_ack_i     (buf_ack),
      .buf_tag_o     (buf_tag),
      .buf_rd_i      (buf_rd),
      .buf_data_o    (buf_data),
      .buf_be_o      (buf_be),
      .buf_last_o    (buf_last),
      .empty_o       (empty)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m = '0;
      for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic mdl_full();
      logic f = 1'b1;
      for (int w = 0; w < 8; w++) f = f & (&mdl_be[w]);
      return f;
   endfunction

   task automatic mdl_clear();
      mdl_valid = 1'b0;
      mdl_tag   = '0;
      for (int w = 0; w < 8; w++) begin
         mdl_data[w] = '0;
         mdl_be[w]   = '0;
      end
   endtask

   task automatic mdl_merge(input logic [22:0] addr, input logic [3:0] be, input logic [31:0] data);
      int w;
      if (!mdl_valid) begin
         mdl_valid = 1'b1;
         mdl_tag   = 18'(addr / 32);
      end
      w = int'((addr / 4) % 8);
      for (int b = 0; b < 4; b++) if (be[b]) mdl_data[w][8*b +: 8] = data[8*b +: 8];
      mdl_be[w] = mdl_be[w] | be;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic do_write(input logic [22:0] addr, input logic [3:0] be, input logic [31:0] data);
      int n = 0;
      wr_req = 1'b1; wr_addr = addr; wr_be = be; wr_data = data;
      #1;
      while (!wr_ready && n < 200) begin
         @(negedge HCLK); #1; n++;
      end
      if (!wr_ready) begin
         chk("write_accept_timeout", 64'(wr_ready), 64'd1);
         wr_req = 1'b0;
         return;
      end
      @(posedge HCLK);
      mdl_merge(addr, be, data);
      @(negedge HCLK);
      wr_req = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge HCLK);
      flush = 1'b0;
   endtask

   task automatic drain_chk(input string nm);
      int n = 0;
      while (!buf_req && n < 100) begin
         @(negedge HCLK); n++;
      end
      chk({nm, "_req"}, 64'(buf_req), 64'd1);
      chk({nm, "_tag"}, 64'(buf_tag), 64'(mdl_tag));
      chk({nm, "_wr_ready_req"}, 64'(wr_ready), 64'd0);
      buf_ack = 1'b1;
      @(negedge HCLK);
      buf_ack = 1'b0;
      chk({nm, "_req_drop"}, 64'(buf_req), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_be%0d", nm, i), 64'(buf_be), 64'(mdl_be[i]));
         chk($sformatf("%s_data%0d", nm, i), 64'(buf_data & lane_mask(mdl_be[i])),
             64'(mdl_data[i] & lane_mask(mdl_be[i])));
         chk($sformatf("%s_last%0d", nm, i), 64'(buf_last), 64'(i == 7));
         buf_rd = 1'b1;
         @(negedge HCLK);
      end
      buf_rd = 1'b0;
      chk({nm, "_empty"}, 64'(empty), 64'd1);
      mdl_clear();
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_wr_ready"}, 64'(wr_ready), 64'd1);
      chk({nm, "_buf_req"},  64'(buf_req),  64'd0);
      chk({nm, "_buf_last"}, 64'(buf_last), 64'd0);
      chk({nm, "_empty"},    64'(empty),    64'd1);
      chk({nm, "_rd_hit"},   64'(rd_hit),   64'd0);
      chk({nm, "_buf_tag"},  64'(buf_tag),  64'd0);
      chk({nm, "_buf_data"}, 64'(buf_data), 64'd0);
      chk({nm, "_buf_be"},   64'(buf_be),   64'd0);
   endtask

   initial begin
      int   n;
      logic saw;
      logic [17:0] rtag;
      logic [2:0]  rw;
      logic [3:0]  rbe;

      PRESETn = 1'b1; wr_req = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
      flush = 0; csr_timeout = '0; rd_chk_addr = '0; buf_ack = 0; buf_rd = 0;
      mdl_clear();
      repeat (2) @(negedge HCLK);
      chk_reset_outputs("rst");
      PRESETn = 1'b0;
      @(negedge HCLK);

      // 1: eight full-word writes complete the block
      for (int i = 0; i < 8; i++) do_write(23'h100 + 23'(4*i), 4'hF, 32'(i));
      chk("t1_req_after_8th", 64'(buf_req), 64'd1);
      chk("t1_tag", 64'(buf_tag), 64'(23'h100 >> 5));
      drain_chk("t1");

      // 2: partial merge then idle timeout; exit decided when timer hits 4, registered one edge later
      csr_timeout = 4'd4;
      do_write(23'h200, 4'h3, 32'hAAAA_1111);
      do_write(23'h200, 4'hC, 32'hBBBB_2222);
      n = 0;
      while (!buf_req && n < 50) begin
         @(negedge HCLK); n++;
      end
      chk("t2_timeout_latency", 64'(n), 64'(4 + 1));
      chk("t2_word0", 64'(mdl_data[0]), 64'h0000_0000_BBBB_1111);
      drain_chk("t2");

      // 3: tag miss holds the new write until the old block drains
      csr_timeout = 4'd0;
      do_write(23'h300, 4'hF, $urandom);
      wr_req = 1'b1; wr_addr = 23'h400; wr_be = 4'hF; wr_data = 32'h4444_0000;
      #1 chk("t3_miss_stall", 64'(wr_ready), 64'd0);
      @(negedge HCLK);
      chk("t3_req", 64'(buf_req), 64'd1);
      drain_chk("t3_old");
      #1 chk("t3_ready_empty", 64'(wr_ready), 64'd1);
      do_write(23'h400, 4'hF, 32'h4444_0000);
      chk("t3_new_tag", 64'(buf_tag), 64'(23'h400 >> 5));
      do_flush();
      drain_chk("t3_new");

      // 4: read hazard detection and flush stalling a hit write
      do_write(23'h500, 4'hF, $urandom);
      rd_chk_addr = 23'h504;
      #1 chk("t4_rd_hit", 64'(rd_hit), 64'd1);
      rd_chk_addr = 23'h604;
      #1 chk("t4_rd_nohit", 64'(rd_hit), 64'd0);
      flush = 1'b1; wr_req = 1'b1; wr_addr = 23'h508; wr_be = 4'hF; wr_data = 32'hDEAD_BEEF;
      #1 chk("t4_flush_stall", 64'(wr_ready), 64'd0);
      @(negedge HCLK);
      flush = 1'b0; wr_req = 1'b0;
      chk("t4_req", 64'(buf_req), 64'd1);
      drain_chk("t4");
      flush = 1'b1;
      repeat (3) @(negedge HCLK);
      flush = 1'b0;
      chk("t4_flush_in_empty", 64'(empty), 64'd1);

      // 5: timeout disabled keeps the block parked
      do_write(23'h0A40, 4'h5, $urandom);
      saw = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge HCLK);
         saw = saw | buf_req;
      end
      chk("t5_no_timeout", 64'(saw), 64'd0);
      do_flush();
      drain_chk("t5");

      // 6: reset in the middle of a drain
      for (int i = 0; i < 4; i++) do_write(23'h700 + 23'(4*i), 4'hF, $urandom);
      do_flush();
      n = 0;
      while (!buf_req && n < 20) begin
         @(negedge HCLK); n++;
      end
      chk("t6_req", 64'(buf_req), 64'd1);
      buf_ack = 1'b1;
      @(negedge HCLK);
      buf_ack = 1'b0;
      buf_rd = 1'b1;
      repeat (3) @(negedge HCLK);
      buf_rd = 1'b0;
      rd_chk_addr = 23'h700;
      PRESETn = 1'b1;
      #1 chk_reset_outputs("t6_rst");
      @(negedge HCLK);
      PRESETn = 1'b0;
      mdl_clear();
      do_write(23'h800, 4'h9, $urandom);
      chk("t6_fresh_tag", 64'(buf_tag), 64'(23'h800 >> 5));
      do_flush();
      drain_chk("t6");

      // 7: random blocks with random lanes, flushed unless they complete on their own
      for (int it = 0; it < 6; it++) begin
         rtag = 18'($urandom);
         n = $urandom_range(1, 40);
         for (int k = 0; k < n && !mdl_full(); k++) begin
            rw  = 3'($urandom);
            rbe = 4'($urandom);
            do_write({rtag, rw, 2'($urandom)}, rbe, $urandom);
         end
         if (mdl_full())
            chk($sformatf("t7_full_req%0d", it), 64'(buf_req), 64'd1);
         else
            do_flush();
         drain_chk($sformatf("t7_%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
